// File: rtl/cps1_pixel_conv.sv
`default_nettype none
// ============================================================================
//  Module   : cps1_pixel_conv
//  Purpose  : CPS1 pixel pipeline. Expands 4-bit colour plus a 4-bit
//             brightness nibble to 8-bit RGB over three register stages.
//             Alongside the pipeline, the input timing is measured to
//             report lock and per-frame mismatch status.
//  Revision : 1.0  initial release
// ============================================================================
module cps1_pixel_conv #(
  parameter int DE_CYC_PER_LINE = 768,
  parameter int ACT_LINES       = 224,
  parameter int LOCK_FRAMES     = 4
) (
  input  logic       PCLK_i,
  input  logic       RST_i,
  input  logic [3:0] R_i,
  input  logic [3:0] G_i,
  input  logic [3:0] B_i,
  input  logic [3:0] F_i,
  input  logic       HSYNC_i,
  input  logic       VSYNC_i,
  input  logic       DE_i,
  input  logic [8:0] xpos_i,
  input  logic [8:0] ypos_i,
  input  logic       frame_change_i,
  output logic [7:0] R_o,
  output logic [7:0] G_o,
  output logic [7:0] B_o,
  output logic       HSYNC_o,
  output logic       VSYNC_o,
  output logic       DE_o,
  output logic [8:0] xpos_o,
  output logic [8:0] ypos_o,
  output logic       locked_o,
  output logic       mismatch_o
);

  localparam logic [10:0] c_DE_CYC      = 11'(DE_CYC_PER_LINE);
  localparam logic [8:0]  c_ACT_LINES   = 9'(ACT_LINES);
  localparam logic [2:0]  c_LOCK_FRAMES = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Exact expansion: floor(c*17*(15+2F)/45). Worst-case product 11475 fits 14 bits.
  function automatic logic [7:0] f_expand(input logic [3:0] c, input logic [3:0] f);
    logic [13:0] w_prod;
    w_prod = 14'(c) * 14'd17 * (14'd15 + {9'd0, f, 1'b0});
    return 8'(w_prod / 14'd45);
  endfunction

  // ---------------------------------------------------------------- pipeline
  logic [3:0] r_s1_r, r_s1_g, r_s1_b, r_s1_f;
  logic       r_s1_hs, r_s1_vs, r_s1_de;
  logic [8:0] r_s1_x, r_s1_y;
  logic [7:0] r_s2_r, r_s2_g, r_s2_b;
  logic       r_s2_hs, r_s2_vs, r_s2_de;
  logic [8:0] r_s2_x, r_s2_y;
  logic [7:0] r_s3_r, r_s3_g, r_s3_b;
  logic       r_s3_hs, r_s3_vs, r_s3_de;
  logic [8:0] r_s3_x, r_s3_y;

  // Three-stage pipeline: capture, expand, blank outside the active area.
  always_ff @(posedge PCLK_i) begin
    if (RST_i) begin
      r_s1_r  <= '0;  r_s1_g  <= '0;  r_s1_b  <= '0;  r_s1_f <= '0;
      r_s1_hs <= 1'b1; r_s1_vs <= 1'b1; r_s1_de <= 1'b0;
      r_s1_x  <= '0;  r_s1_y  <= '0;
      r_s2_r  <= '0;  r_s2_g  <= '0;  r_s2_b  <= '0;
      r_s2_hs <= 1'b1; r_s2_vs <= 1'b1; r_s2_de <= 1'b0;
      r_s2_x  <= '0;  r_s2_y  <= '0;
      r_s3_r  <= '0;  r_s3_g  <= '0;  r_s3_b  <= '0;
      r_s3_hs <= 1'b1; r_s3_vs <= 1'b1; r_s3_de <= 1'b0;
      r_s3_x  <= '0;  r_s3_y  <= '0;
    end else begin
      r_s1_r  <= R_i;     r_s1_g  <= G_i;     r_s1_b  <= B_i;  r_s1_f <= F_i;
      r_s1_hs <= HSYNC_i; r_s1_vs <= VSYNC_i; r_s1_de <= DE_i;
      r_s1_x  <= xpos_i;  r_s1_y  <= ypos_i;

      r_s2_r  <= f_expand(r_s1_r, r_s1_f);
      r_s2_g  <= f_expand(r_s1_g, r_s1_f);
      r_s2_b  <= f_expand(r_s1_b, r_s1_f);
      r_s2_hs <= r_s1_hs; r_s2_vs <= r_s1_vs; r_s2_de <= r_s1_de;
      r_s2_x  <= r_s1_x;  r_s2_y  <= r_s1_y;

      r_s3_r  <= r_s2_de ? r_s2_r : 8'd0;
      r_s3_g  <= r_s2_de ? r_s2_g : 8'd0;
      r_s3_b  <= r_s2_de ? r_s2_b : 8'd0;
      r_s3_hs <= r_s2_hs; r_s3_vs <= r_s2_vs; r_s3_de <= r_s2_de;
      r_s3_x  <= r_s2_x;  r_s3_y  <= r_s2_y;
    end
  end

  assign R_o     = r_s3_r;
  assign G_o     = r_s3_g;
  assign B_o     = r_s3_b;
  assign HSYNC_o = r_s3_hs;
  assign VSYNC_o = r_s3_vs;
  assign DE_o    = r_s3_de;
  assign xpos_o  = r_s3_x;
  assign ypos_o  = r_s3_y;

  // ---------------------------------------------------------- timing monitor
  logic        r_de_prev, r_fc_prev, r_first, r_bad;
  logic [10:0] r_decnt;
  logic [8:0]  r_lines;
  logic        w_rise, w_fall, w_fc_acc, w_eval, w_line_bad, w_good;

  assign w_rise     = DE_i & ~r_de_prev;
  assign w_fall     = ~DE_i & r_de_prev;
  // A pulse held over consecutive cycles only counts on its first cycle.
  assign w_fc_acc   = frame_change_i & ~r_fc_prev;
  assign w_eval     = w_fc_acc & ~r_first;
  // A line ending in the evaluation cycle still belongs to the old frame.
  assign w_line_bad = w_fall & (r_decnt != c_DE_CYC);
  assign w_good     = (r_lines == c_ACT_LINES) & ~r_bad & ~w_line_bad & ~DE_i;

  // Per-line DE cycle count, per-frame line count and bad-line flag.
  always_ff @(posedge PCLK_i) begin
    if (RST_i) begin
      r_de_prev <= 1'b0;
      r_fc_prev <= 1'b0;
      r_first   <= 1'b1;
      r_bad     <= 1'b0;
      r_decnt   <= '0;
      r_lines   <= '0;
    end else begin
      r_de_prev <= DE_i;
      r_fc_prev <= frame_change_i;

      if (w_rise)
        r_decnt <= 11'd1;
      else if (DE_i && r_decnt != 11'h7FF)
        r_decnt <= r_decnt + 11'd1;

      if (w_fc_acc) begin
        // A line starting in the evaluation cycle belongs to the new frame.
        r_first <= 1'b0;
        r_bad   <= 1'b0;
        r_lines <= w_rise ? 9'd1 : 9'd0;
      end else begin
        if (w_line_bad)
          r_bad <= 1'b1;
        if (w_rise && r_lines != 9'h1FF)
          r_lines <= r_lines + 9'd1;
      end
    end
  end

  // ---------------------------------------------------------- lock FSM
  state_t     r_state, w_state_nxt;
  logic [2:0] r_gcnt, w_gcnt_nxt, w_gcnt_inc;
  logic       r_locked, r_mismatch;

  assign w_gcnt_inc = r_gcnt + 3'd1;

  // State, good-frame counter and registered status outputs.
  always_ff @(posedge PCLK_i) begin
    if (RST_i) begin
      r_state    <= ST_UNLOCKED;
      r_gcnt     <= '0;
      r_locked   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_mismatch <= w_eval & ~w_good;
    end
  end

  // Next-state decode, advanced only on an evaluated frame boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_gcnt_nxt  = r_gcnt;
    if (w_eval) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_good) begin
            w_gcnt_nxt  = 3'd1;
            w_state_nxt = (3'd1 >= c_LOCK_FRAMES) ? ST_LOCKED : ST_CHECKING;
          end
        end
        ST_CHECKING: begin
          if (w_good) begin
            w_gcnt_nxt  = w_gcnt_inc;
            w_state_nxt = (w_gcnt_inc >= c_LOCK_FRAMES) ? ST_LOCKED : ST_CHECKING;
          end else begin
            w_gcnt_nxt  = 3'd0;
            w_state_nxt = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (!w_good) begin
            w_gcnt_nxt  = 3'd0;
            w_state_nxt = ST_UNLOCKED;
          end
        end
        default: begin
          w_gcnt_nxt  = 3'd0;
          w_state_nxt = ST_UNLOCKED;
        end
      endcase
    end
  end

  assign locked_o   = r_locked;
  assign mismatch_o = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_cps1_pixel_conv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cps1_pixel_conv
//  Purpose  : Directed self-checking bench for cps1_pixel_conv. Timing
//             parameters are scaled down so frame sequences stay short.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cps1_pixel_conv;

  localparam int DE_CYC = 16;
  localparam int LINES  = 6;
  localparam int LOCKF  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] r_in, g_in, b_in, f_in;
  logic       hs_in, vs_in, de_in, fc_in;
  logic [8:0] x_in, y_in;
  logic [7:0] r_out, g_out, b_out;
  logic       hs_out, vs_out, de_out, lock_out, mm_out;
  logic [8:0] x_out, y_out;

  int n_cmp = 0;
  int n_err = 0;
  int mm_cnt = 0;

  cps1_pixel_conv #(
    .DE_CYC_PER_LINE(DE_CYC),
    .ACT_LINES      (LINES),
    .LOCK_FRAMES    (LOCKF)
  ) dut (
    .PCLK_i        (clk),
    .RST_i         (rst),
    .R_i           (r_in),
    .G_i           (g_in),
    .B_i           (b_in),
    .F_i           (f_in),
    .HSYNC_i       (hs_in),
    .VSYNC_i       (vs_in),
    .DE_i          (de_in),
    .xpos_i        (x_in),
    .ypos_i        (y_in),
    .frame_change_i(fc_in),
    .R_o           (r_out),
    .G_o           (g_out),
    .B_o           (b_out),
    .HSYNC_o       (hs_out),
    .VSYNC_o       (vs_out),
    .DE_o          (de_out),
    .xpos_o        (x_out),
    .ypos_o        (y_out),
    .locked_o      (lock_out),
    .mismatch_o    (mm_out)
  );

  always #5 clk = ~clk;

  // Running tally of mismatch pulses, sampled away from the active edge.
  always @(negedge clk) if (mm_out === 1'b1) mm_cnt++;

  typedef struct {
    logic [3:0] r, g, b, f;
    logic       hs, vs, de;
    logic [8:0] x, y;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t vecs[8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_line(input int n);
    de_in = 1'b1;
    repeat (n) step;
    de_in = 1'b0;
    repeat (3) step;
  endtask

  task automatic send_lines(input int nl, input int badidx);
    for (int l = 0; l < nl; l++)
      send_line((l == badidx) ? DE_CYC - 1 : DE_CYC);
  endtask

  // Single-cycle frame_change pulse; checks status on the following cycles.
  task automatic fc_check(input string name, input logic exp_lock, input logic exp_mm);
    fc_in = 1'b1;
    step;
    fc_in = 1'b0;
    chk({name, "_lock"}, 64'(lock_out), 64'(exp_lock));
    chk({name, "_mm"},   64'(mm_out),   64'(exp_mm));
    step;
    chk({name, "_mm_clr"}, 64'(mm_out), 64'd0);
  endtask

  initial begin
    //            r     g     b     f     hs    vs    de    x       y       er     eg     eb
    vecs[0] = '{4'd15, 4'd1,  4'd8,  4'd15, 1'b1, 1'b1, 1'b1, 9'd10,  9'd20,  8'd255, 8'd17, 8'd136};
    vecs[1] = '{4'd15, 4'd1,  4'd8,  4'd0,  1'b0, 1'b1, 1'b1, 9'd11,  9'd20,  8'd85,  8'd5,  8'd45};
    vecs[2] = '{4'd8,  4'd0,  4'd15, 4'd7,  1'b1, 1'b0, 1'b1, 9'd12,  9'd21,  8'd87,  8'd0,  8'd164};
    vecs[3] = '{4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 9'd300, 9'd200, 8'd0,   8'd0,  8'd0};
    vecs[4] = '{4'd1,  4'd2,  4'd3,  4'd1,  1'b1, 1'b0, 1'b1, 9'd511, 9'd511, 8'd6,   8'd12, 8'd19};
    vecs[5] = '{4'd4,  4'd5,  4'd6,  4'd8,  1'b1, 1'b1, 1'b1, 9'd0,   9'd1,   8'd46,  8'd58, 8'd70};
    vecs[6] = '{4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 9'd5,   9'd6,   8'd0,   8'd0,  8'd0};
    vecs[7] = '{4'd0,  4'd7,  4'd12, 4'd3,  1'b1, 1'b1, 1'b1, 9'd77,  9'd88,  8'd0,   8'd55, 8'd95};

    rst = 1'b1; fc_in = 1'b0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    r_in = 4'd15; g_in = 4'd15; b_in = 4'd15; f_in = 4'd15; x_in = 9'd3; y_in = 9'd4;
    step;
    chk("reset_state", {r_out, g_out, b_out, hs_out, vs_out, de_out, x_out, y_out, lock_out, mm_out},
        {24'd0, 1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 1'b0, 1'b0});
    rst = 1'b0;
    step;

    // Streamed vectors: output for vector k must appear exactly 3 edges later.
    for (int k = 0; k < 11; k++) begin
      if (k >= 3)
        chk($sformatf("pix_vec%0d", k - 3),
            {r_out, g_out, b_out, hs_out, vs_out, de_out, x_out, y_out},
            {vecs[k-3].er, vecs[k-3].eg, vecs[k-3].eb, vecs[k-3].hs, vecs[k-3].vs,
             vecs[k-3].de, vecs[k-3].x, vecs[k-3].y});
      if (k < 8) begin
        r_in = vecs[k].r; g_in = vecs[k].g; b_in = vecs[k].b; f_in = vecs[k].f;
        hs_in = vecs[k].hs; vs_in = vecs[k].vs; de_in = vecs[k].de;
        x_in = vecs[k].x; y_in = vecs[k].y;
      end else begin
        de_in = 1'b0;
      end
      step;
    end

    // Lock sequence: measurement boundary then LOCKF good frames.
    r_in = 4'd15; g_in = 4'd15; b_in = 4'd15; f_in = 4'd15;
    hs_in = 1'b0; vs_in = 1'b0; x_in = 9'd33; y_in = 9'd44; de_in = 1'b0;
    repeat (3) step;
    fc_check("measure", 1'b0, 1'b0);
    for (int fr = 1; fr <= LOCKF; fr++) begin
      send_lines(LINES, -1);
      fc_check($sformatf("lock_fr%0d", fr), (fr == LOCKF), 1'b0);
    end
    chk("lock_no_mm", 64'(mm_cnt), 64'd0);

    // Loss of lock through one short line, then relock.
    send_lines(LINES, 2);
    fc_check("short_line", 1'b0, 1'b1);
    chk("short_line_once", 64'(mm_cnt), 64'd1);
    for (int fr = 1; fr <= LOCKF; fr++) begin
      if (fr == 2) begin
        // Last line's falling edge lands in the evaluation cycle.
        send_lines(LINES - 1, -1);
        de_in = 1'b1;
        repeat (DE_CYC) step;
        de_in = 1'b0;
      end else begin
        send_lines(LINES, -1);
      end
      if (fr == 3) begin
        // Double pulse: only the first cycle is evaluated.
        fc_in = 1'b1;
        step;
        chk("dbl_fc_mm", 64'(mm_out), 64'd0);
        step;
        fc_in = 1'b0;
        chk("dbl_fc_second", 64'(mm_out), 64'd0);
        step;
      end else begin
        fc_check($sformatf("relock_fr%0d", fr), (fr == LOCKF), 1'b0);
      end
    end
    chk("relock_mm_total", 64'(mm_cnt), 64'd1);

    // One line missing from the frame.
    send_lines(LINES - 1, -1);
    fc_check("short_frame", 1'b0, 1'b1);
    for (int fr = 1; fr <= LOCKF; fr++) begin
      send_lines(LINES, -1);
      fc_check($sformatf("pre_rst_fr%0d", fr), (fr == LOCKF), 1'b0);
    end

    // Reset mid-line while locked.
    send_lines(2, -1);
    de_in = 1'b1;
    repeat (6) step;
    chk("pre_rst_active", {de_out, r_out, lock_out}, {1'b1, 8'd255, 1'b1});
    rst = 1'b1;
    step;
    chk("mid_rst_state", {r_out, g_out, b_out, hs_out, vs_out, de_out, x_out, y_out, lock_out, mm_out},
        {24'd0, 1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 1'b0, 1'b0});
    rst = 1'b0;
    de_in = 1'b0;
    repeat (3) step;
    // Partial frame: would be bad, but this boundary only restarts measurement.
    send_lines(2, -1);
    fc_check("post_rst_measure", 1'b0, 1'b0);
    for (int fr = 1; fr <= LOCKF; fr++) begin
      send_lines(LINES, -1);
      fc_check($sformatf("post_rst_fr%0d", fr), (fr == LOCKF), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cps1_pixel_conv.md
CPS1_PIXEL_CONV -- requirements
Module: cps1_pixel_conv

Interface
REQ-001 SHALL have parameter DE_CYC_PER_LINE, default 768: expected PCLK_i cycles with DE_i high per active line.
REQ-002 SHALL have parameter ACT_LINES, default 224: expected DE-active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 4: consecutive matching frames required for lock.
REQ-004 SHALL have ports:
- PCLK_i  in  1  pixel clock, sole clock.
- RST_i  in  1  synchronous, active-high reset.
- R_i, G_i, B_i, F_i  in  4 each  colour nibbles and brightness nibble.
- HSYNC_i, VSYNC_i, DE_i  in  1 each  timing from the sync frontend, active-low syncs.
- xpos_i, ypos_i  in  9 each  active-area coordinates.
- frame_change_i  in  1  one-cycle pulse per frame start.
- R_o, G_o, B_o  out  8 each  expanded colour.
- HSYNC_o, VSYNC_o, DE_o  out  1 each  delayed timing.
- xpos_o, ypos_o  out  9 each  delayed coordinates.
- locked_o  out  1  timing lock status.
- mismatch_o  out  1  one-cycle pulse on a failed frame check.

Function
REQ-005 SHALL compute each colour output as floor(c*17*(15+2*F_i)/45), where c is the 4-bit channel value.
- Range: F=15, c=15 gives 255; F=0, c=15 gives 85.
- Implementation SHALL be an exact 256-entry table or equivalent logic; no approximation.
REQ-006 SHALL have a fixed latency of 3 PCLK_i cycles from inputs to R/G/B_o.
REQ-007 SHALL delay HSYNC, VSYNC, DE, xpos and ypos by exactly 3 cycles so they stay aligned with the colour outputs.
REQ-008 SHALL force R/G/B_o to 0 in any cycle where DE_o is 0.
REQ-009 SHALL count DE_i-high cycles within each line (11-bit, saturating at 2047); the count clears on each DE_i rising edge.
REQ-010 SHALL, on each DE_i falling edge, mark the line bad if the count is not equal to DE_CYC_PER_LINE.
REQ-011 SHALL count DE_i rising edges per frame (9-bit, saturating at 511).
REQ-012 SHALL evaluate the completed frame on frame_change_i. The frame is good iff:
- the line count equals ACT_LINES;
- no bad line was seen;
- DE_i was not high during the frame_change_i cycle.
REQ-013 SHALL, on frame_change_i, clear the line count and the bad-line flag in the same cycle they are evaluated.
REQ-014 SHALL ignore the first frame_change_i after reset for evaluation purposes and only start measuring from it.
REQ-015 SHALL implement states UNLOCKED, CHECKING and LOCKED, with a 3-bit good-frame counter gcnt:
- UNLOCKED: good frame -> CHECKING with gcnt=1; bad frame -> stay.
- CHECKING: good frame -> gcnt+1; on reaching LOCK_FRAMES -> LOCKED. Bad frame -> UNLOCKED, gcnt=0.
- LOCKED: good frame -> stay; bad frame -> UNLOCKED, gcnt=0.
REQ-016 SHALL drive locked_o high iff the state is LOCKED, registered, and updated the cycle after the evaluating frame_change_i.
REQ-017 SHALL pulse mismatch_o high for exactly one cycle, the cycle after any bad-frame evaluation, in every state.
REQ-018 SHALL give priority to the frame evaluation when a DE_i edge coincides with frame_change_i:
- a rising DE_i edge in the evaluation cycle counts toward the next frame;
- a falling DE_i edge in that cycle counts toward the frame being evaluated.
REQ-019 SHALL ignore frame_change_i pulses arriving on consecutive cycles after the first; the second pulse is neither evaluated nor restarts measurement.

Reset
REQ-020 SHALL, when RST_i is high at a clock edge, set the following on that edge; this holds mid-frame and mid-line:
- R/G/B_o = 0; DE_o = 0; HSYNC_o = 1; VSYNC_o = 1; xpos_o = 0; ypos_o = 0;
- all pipeline stages with DE cleared and syncs high;
- state UNLOCKED; gcnt = 0; all counters 0; first-frame flag set;
- locked_o = 0; mismatch_o = 0.
REQ-021 SHALL require no RST_i release sequencing; normal operation starts on the first edge with RST_i low.

Verification
REQ-022 Colour table scenarios:
- R=15, G=1, B=8 with F=15 -> 255/17/136.
- Same colours with F=0 -> 85/5/45.
- R=8, F=7 -> 87.
- Each result appears exactly 3 cycles later with DE_i high.
REQ-023 DE_i low with R=G=B=15 -> R/G/B_o = 0; HSYNC/VSYNC/xpos/ypos reproduced with 3-cycle delay.
REQ-024 Lock sequence: one measurement frame plus 4 nominal frames (224 lines x 768 DE cycles) -> locked_o rises 1 cycle after the 5th frame_change_i, and mismatch_o never pulses.
REQ-025 Loss of lock: while LOCKED, feed one frame containing a single line of 767 DE cycles -> mismatch_o pulses once and locked_o falls 1 cycle after that frame's frame_change_i. A further 4 good frames -> locked_o relocks.
REQ-026 Line-count and reset: a frame of 223 lines -> mismatch_o pulses. RST_i asserted mid-frame while LOCKED -> all outputs reach reset values on the next edge, and the next frame_change_i is not evaluated.
